ap_ctrl_driver: RTL and testbench
=================================

# ap_ctrl_driver

Synthesizable initiator for the HLS block-level control handshake (ap_start / ap_ready / ap_done / ap_continue) that our dataflow monitors observe. It drives a kernel such as AES_Encrypt through a programmed number of back-to-back or gapped invocations and measures per-invocation latency and handshake stalls. It sits between a host/test controller and the kernel's control ports, replacing hand-written start sequencing in benches and on-board self-test.

## Interface

Parameters:
- NUM_W, 16, width of the invocation count.
- CNT_W, 32, width of all cycle counters; all counters saturate at all-ones.
- CHAIN, 0, 0 = ap_ctrl_hs (ap_continue tied 1); 1 = ap_ctrl_chain (ap_continue gated by sink_ready).

Ports:
- ap_clk  in  1  single clock, all logic rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request, sampled only in IDLE.
- cmd_num  in  NUM_W  invocations to issue, latched with cmd_start.
- cmd_gap  in  8  idle cycles inserted between invocations, latched with cmd_start.
- cmd_abort  in  1  level; stop after the in-flight invocation completes.
- cmd_busy  out  1  high in any state other than IDLE.
- cmd_done  out  1  one-cycle pulse when the command finishes or aborts.
- kern_ap_start  out  1  registered ap_start to the kernel.
- kern_ap_ready  in  1  kernel ap_ready.
- kern_ap_done  in  1  kernel ap_done.
- kern_ap_continue  out  1  kernel ap_continue.
- sink_ready  in  1  downstream ready; used only when CHAIN=1.
- txn_count  out  NUM_W  invocations completed in the current command.
- lat_last  out  CNT_W  latency of the most recent completed invocation.
- lat_max  out  CNT_W  maximum latency in the current command.
- stall_cycles  out  CNT_W  cycles with kern_ap_start=1 and kern_ap_ready=0.
- total_cycles  out  CNT_W  cycles from the first ap_start assertion to cmd_done.

## Operation

- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE: on cmd_start, latch cmd_num/cmd_gap and clear all statistics.
  - If cmd_num=0, pulse cmd_done next cycle and stay in IDLE; ap_start never asserts.
  - Otherwise go to ISSUE.
- ISSUE: kern_ap_start=1. Hold until kern_ap_ready=1 (never withdrawn, including on abort). On ready:
  - If kern_ap_done is also high in the same cycle, the invocation completes this cycle and next-state selection is as for WAIT_DONE completion.
  - Otherwise go to WAIT_DONE.
- WAIT_DONE: completion = kern_ap_done & kern_ap_continue. On completion, increment txn_count and update lat_last/lat_max. Next state:
  - If txn_count reaches num or cmd_abort=1: go to IDLE and pulse cmd_done.
  - Else if gap=0: go to ISSUE.
  - Else: go to GAP.
- GAP: count gap cycles with ap_start low, then go to ISSUE. cmd_abort in GAP goes to IDLE with cmd_done.
- kern_ap_continue:
  - CHAIN=0: constant 1.
  - CHAIN=1: sink_ready while in WAIT_DONE or ISSUE, else 0.
  - ap_done held without continue is not a completion.
- Latency: counts from the first cycle ap_start is high for the invocation through the completion cycle, inclusive. Minimum value is 1 (ready and done coincide with the first start cycle).
- Statistics hold their values in IDLE until the next accepted cmd_start.

## Timing

- Reset values: every output 0, except kern_ap_continue = (CHAIN==0). State returns to IDLE.
- Reset is asynchronous mid-operation: kern_ap_start drops immediately and no cmd_done is issued.
- cmd_start in cycle T produces kern_ap_start=1 in cycle T+1. cmd_busy is also high from T+1.
- kern_ap_ready in cycle R:
  - kern_ap_start is 0 in R+1 when gap>0, on the last invocation, or while awaiting done.
  - kern_ap_start stays 1 in R+1 for a back-to-back invocation when done coincided with R and gap=0.
- Gap of G: kern_ap_start is low for exactly G cycles between completion and the next assertion.
- cmd_done pulses in the cycle after the final completion. cmd_busy falls in that same cycle.
- cmd_start while busy is ignored.
- Abort asserted during ISSUE takes effect only at that invocation's completion.

## Test plan

- **Back-to-back**: cmd_num=3, gap=0, kernel ready and done 10 cycles after start → ap_start high 3×10 cycles continuously; txn_count=3, lat_last=lat_max=10, stall_cycles=27, cmd_done pulses once.
- **Zero count**: cmd_num=0 → cmd_done one cycle after cmd_start, kern_ap_start never 1, all statistics 0.
- **Gapped, variable latency**: cmd_num=2, gap=4, latencies 5 then 12 (ready on the first start cycle) → ap_start low exactly 4 cycles between invocations; lat_last=12, lat_max=12, stall_cycles=0.
- **Chain backpressure**: CHAIN=1, done asserted and held while sink_ready=0 for 6 cycles → no completion counted until sink_ready=1; latency includes the 6 cycles.
- **Abort**: abort raised while ap_start is waiting on ready, cmd_num=5 → ap_start held until ready, one invocation completes, cmd_done follows, txn_count=1.
- **Reset mid-operation**: ap_rst_n low in WAIT_DONE → all outputs 0 asynchronously, no cmd_done; a new command after release runs normally.

Source files
------------

// File: rtl/ap_ctrl_driver.sv
// Initiator for the HLS ap_start/ap_ready/ap_done/ap_continue handshake.
// Issues a programmed number of invocations and gathers latency/stall statistics.
`timescale 1ns/1ps
module ap_ctrl_driver #(
  parameter int NUM_W = 16,
  parameter int CNT_W = 32,
  parameter int CHAIN = 0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_start,
  input  logic [NUM_W-1:0] cmd_num,
  input  logic [7:0]       cmd_gap,
  input  logic             cmd_abort,
  output logic             cmd_busy,
  output logic             cmd_done,
  output logic             kern_ap_start,
  input  logic             kern_ap_ready,
  input  logic             kern_ap_done,
  output logic             kern_ap_continue,
  input  logic             sink_ready,
  output logic [NUM_W-1:0] txn_count,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] total_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  typedef struct packed {
    logic [NUM_W-1:0] txn;
    logic [CNT_W-1:0] lat_last;
    logic [CNT_W-1:0] lat_max;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] total;
  } stats_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  stats_t           st_q, st_d;
  logic             done_q, done_d;

  logic             cont;
  logic             complete;
  logic [NUM_W-1:0] txn_inc;
  logic [CNT_W-1:0] lat_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ap_continue only gates completion while an invocation is actually in flight.
  always_comb begin
    if (CHAIN != 0) cont = sink_ready && (state_q == S_ISSUE || state_q == S_WAIT);
    else            cont = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    lat_cnt_d = lat_cnt_q;
    st_d      = st_q;
    done_d    = 1'b0;
    complete  = 1'b0;
    txn_inc   = st_q.txn + NUM_W'(1);
    lat_now   = sat_inc(lat_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          num_d     = cmd_num;
          gap_d     = cmd_gap;
          st_d      = '0;
          lat_cnt_d = '0;
          if (cmd_num == '0) done_d  = 1'b1;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!kern_ap_ready) st_d.stall = sat_inc(st_q.stall);
        else if (kern_ap_done && cont) complete = 1'b1;
        else state_d = S_WAIT;
      end
      S_WAIT: begin
        if (kern_ap_done && cont) complete = 1'b1;
      end
      S_GAP: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gcnt_q <= 8'd1) begin
          state_d = S_ISSUE;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) st_d.total = sat_inc(st_q.total);

    // Latency counter spans ISSUE+WAIT and is rearmed at each completion.
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      if (complete) begin
        st_d.txn      = txn_inc;
        st_d.lat_last = lat_now;
        if (lat_now > st_q.lat_max) st_d.lat_max = lat_now;
        lat_cnt_d = '0;
        if (txn_inc == num_q || cmd_abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == 8'd0) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_GAP;
          gcnt_d  = gap_q;
        end
      end else begin
        lat_cnt_d = lat_now;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      lat_cnt_q <= '0;
      st_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      lat_cnt_q <= lat_cnt_d;
      st_q      <= st_d;
      done_q    <= done_d;
    end
  end

  assign cmd_busy         = (state_q != S_IDLE);
  assign cmd_done         = done_q;
  assign kern_ap_start    = (state_q == S_ISSUE);
  assign kern_ap_continue = cont;
  assign txn_count        = st_q.txn;
  assign lat_last         = st_q.lat_last;
  assign lat_max          = st_q.lat_max;
  assign stall_cycles     = st_q.stall;
  assign total_cycles     = st_q.total;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Scoreboard bench: two DUTs (hs and chain), a timed kernel model, and a cmd_done monitor.
`timescale 1ns/1ps
module tb_ap_ctrl_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        cmd_start, cmd_abort, sink_ready;
  logic [15:0] cmd_num;
  logic [7:0]  cmd_gap;
  logic        kern_ready, kern_done;

  logic        busy0, done0, start0, cont0, busy1, done1, start1, cont1;
  logic [15:0] txn0, txn1;
  logic [31:0] ll0, lm0, st0, tot0, ll1, lm1, st1, tot1;

  ap_ctrl_driver #(.NUM_W(16), .CNT_W(32), .CHAIN(0)) u_hs (
    .ap_clk(clk), .ap_rst_n(rst_n), .cmd_start(cmd_start & ~sel), .cmd_num(cmd_num),
    .cmd_gap(cmd_gap), .cmd_abort(cmd_abort), .cmd_busy(busy0), .cmd_done(done0),
    .kern_ap_start(start0), .kern_ap_ready(kern_ready), .kern_ap_done(kern_done),
    .kern_ap_continue(cont0), .sink_ready(sink_ready), .txn_count(txn0), .lat_last(ll0),
    .lat_max(lm0), .stall_cycles(st0), .total_cycles(tot0));

  ap_ctrl_driver #(.NUM_W(16), .CNT_W(32), .CHAIN(1)) u_ch (
    .ap_clk(clk), .ap_rst_n(rst_n), .cmd_start(cmd_start & sel), .cmd_num(cmd_num),
    .cmd_gap(cmd_gap), .cmd_abort(cmd_abort), .cmd_busy(busy1), .cmd_done(done1),
    .kern_ap_start(start1), .kern_ap_ready(kern_ready), .kern_ap_done(kern_done),
    .kern_ap_continue(cont1), .sink_ready(sink_ready), .txn_count(txn1), .lat_last(ll1),
    .lat_max(lm1), .stall_cycles(st1), .total_cycles(tot1));

  logic        busy_m, done_m, start_m, cont_m;
  logic [15:0] txn_m;
  logic [31:0] ll_m, lm_m, st_m, tot_m;
  assign busy_m  = sel ? busy1  : busy0;
  assign done_m  = sel ? done1  : done0;
  assign start_m = sel ? start1 : start0;
  assign cont_m  = sel ? cont1  : cont0;
  assign txn_m   = sel ? txn1   : txn0;
  assign ll_m    = sel ? ll1    : ll0;
  assign lm_m    = sel ? lm1    : lm0;
  assign st_m    = sel ? st1    : st0;
  assign tot_m   = sel ? tot1   : tot0;

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Kernel model: per invocation, ready once age>=rdy_at, done once age>=done_at.
  int rdy_at[64];
  int done_at[64];
  int k_age, k_inv;
  logic k_inflight;
  logic comp_flag;
  int since_comp, last_gap;

  assign kern_ready = start_m && (k_age >= rdy_at[k_inv % 64]);
  assign kern_done  = ((start_m && k_age >= rdy_at[k_inv % 64]) || k_inflight) &&
                      (k_age >= done_at[k_inv % 64]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_age <= 0; k_inv <= 0; k_inflight <= 1'b0;
      comp_flag <= 1'b0; since_comp <= 0; last_gap <= 0;
    end else begin
      if (kern_done && cont_m) begin
        k_age <= 0; k_inflight <= 1'b0; k_inv <= k_inv + 1;
        comp_flag <= 1'b1; since_comp <= 0;
      end else begin
        if (start_m || k_inflight) begin
          k_age <= k_age + 1;
          if (start_m && kern_ready) k_inflight <= 1'b1;
        end
        if (comp_flag && start_m) begin
          last_gap <= since_comp; comp_flag <= 1'b0;
        end else if (comp_flag) begin
          since_comp <= since_comp + 1;
        end
      end
    end
  end

  int hi_cnt = 0, rise_cnt = 0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (start_m) begin
      hi_cnt <= hi_cnt + 1;
      if (!start_prev) rise_cnt <= rise_cnt + 1;
    end
    start_prev <= start_m;
  end

  typedef struct { longint txn, ll, lm, st, tot; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_m) begin
      if (exp_q.size() == 0) chk("unexpected_done", done_m, 0);
      else begin
        e = exp_q.pop_front();
        chk("txn_count", txn_m, e.txn);
        chk("lat_last", ll_m, e.ll);
        chk("lat_max", lm_m, e.lm);
        chk("stall_cycles", st_m, e.st);
        chk("total_cycles", tot_m, e.tot);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_inv(input int i, input int r, input int d);
    rdy_at[(k_inv + i) % 64]  = r;
    done_at[(k_inv + i) % 64] = d;
  endtask

  task automatic issue(input int num, input int gap);
    cmd_num = 16'(num); cmd_gap = 8'(gap); cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while ((busy_m || exp_q.size() != 0) && n < 300) begin cyc(); n++; end
    if (n >= 300) begin
      chk("timeout_busy", busy_m, 0);
      chk("timeout_pending", exp_q.size(), 0);
    end
  endtask

  initial begin
    int hb, rb, n;
    sel = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; sink_ready = 1'b0;
    cmd_num = '0; cmd_gap = '0;
    for (int i = 0; i < 64; i++) begin rdy_at[i] = 0; done_at[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_txn", txn0, 0);
    chk("rst_total", tot0, 0);
    chk("rst_cont_hs", cont0, 1);
    chk("rst_cont_chain", cont1, 0);
    chk("rst_start_chain", start1, 0);
    rst_n = 1'b1;
    cyc();

    // back-to-back, ready+done on the 10th start cycle
    for (int i = 0; i < 3; i++) set_inv(i, 9, 9);
    exp_q.push_back('{3, 10, 10, 27, 30});
    hb = hi_cnt; rb = rise_cnt;
    issue(3, 0);
    chk("b2b_start_t1", start_m, 1);
    chk("b2b_busy_t1", busy_m, 1);
    wait_end();
    chk("b2b_start_hi", hi_cnt - hb, 30);
    chk("b2b_rises", rise_cnt - rb, 1);
    chk("b2b_gap", last_gap, 0);

    // zero count
    exp_q.push_back('{0, 0, 0, 0, 0});
    hb = hi_cnt;
    issue(0, 0);
    chk("zero_done_t1", done_m, 1);
    chk("zero_busy", busy_m, 0);
    wait_end();
    chk("zero_start_hi", hi_cnt - hb, 0);

    // gap 4, latencies 5 then 12
    set_inv(0, 0, 4); set_inv(1, 0, 11);
    exp_q.push_back('{2, 12, 12, 0, 21});
    issue(2, 4);
    wait_end();
    chk("gap4_len", last_gap, 4);

    // gap 1, longer latency first so lat_max != lat_last
    set_inv(0, 6, 6); set_inv(1, 2, 2);
    exp_q.push_back('{2, 3, 7, 8, 11});
    issue(2, 1);
    wait_end();
    chk("gap1_len", last_gap, 1);

    // chain backpressure: done held 6 cycles with sink_ready low
    sel = 1'b1; sink_ready = 1'b0;
    set_inv(0, 0, 2);
    exp_q.push_back('{1, 9, 9, 0, 9});
    issue(1, 0);
    n = 0;
    for (int g = 0; g < 50 && n < 6; g++) begin
      cyc();
      if (kern_done) begin
        n++;
        chk("chain_hold_txn", txn_m, 0);
        chk("chain_hold_cont", cont_m, 0);
      end
    end
    chk("chain_done_seen", n, 6);
    cyc();
    sink_ready = 1'b1;
    #1;
    chk("chain_cont_on", cont_m, 1);
    wait_end();
    chk("chain_cont_idle", cont_m, 0);
    sink_ready = 1'b0;
    sel = 1'b0;
    cyc();

    // abort while start waits on ready
    set_inv(0, 4, 6);
    exp_q.push_back('{1, 7, 7, 4, 7});
    issue(5, 0);
    cyc();
    cmd_abort = 1'b1;
    cyc(); cyc();
    chk("abort_hold_start", start_m, 1);
    wait_end();
    cmd_abort = 1'b0;
    chk("abort_busy", busy_m, 0);

    // asynchronous reset in WAIT_DONE
    set_inv(0, 0, 20);
    issue(2, 0);
    repeat (3) cyc();
    chk("pre_rst_busy", busy_m, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", start_m, 0);
    chk("arst_busy", busy_m, 0);
    chk("arst_total", tot_m, 0);
    chk("arst_done", done_m, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    set_inv(0, 2, 2);
    exp_q.push_back('{1, 3, 3, 2, 3});
    issue(1, 0);
    wait_end();
    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
